// File: rtl/quadrature_debounce.sv
// Input conditioning for a rotary encoder: two-flop synchroniser on each
// contact, a power-up settle phase, then a per-channel stability counter.
// Flags the case where both debounced channels change on the same edge.
module quadrature_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic quadA_in,
    input  logic quadB_in,
    input  logic err_clr,
    output logic quadA,
    output logic quadB,
    output logic valid,
    output logic step,
    output logic err,
    output logic err_sticky
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state, state_n;
    logic [1:0]              sync1, sync2;   // bit 0 = A, bit 1 = B
    logic [1:0]              snap, snap_n;
    logic [1:0]              dout, dout_n;
    logic [CNT_W-1:0]        init_cnt, init_cnt_n;
    logic [1:0][CNT_W-1:0]   ch_cnt, ch_cnt_n;
    logic [1:0]              upd;
    logic                    valid_n, step_n, err_n, sticky_n;

    assign quadA = dout[0];
    assign quadB = dout[1];

    // Two-stage synchroniser for the asynchronous contacts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {quadB_in, quadA_in};
            sync2 <= sync1;
        end
    end

    // Per-channel stability counters; held at zero until RUN so that
    // they start clean when the settle phase completes.
    always_comb begin
        upd      = 2'b00;
        ch_cnt_n = ch_cnt;
        for (int i = 0; i < 2; i++) begin
            if (state != S_RUN || sync2[i] == dout[i]) begin
                // Any return to the current output level restarts the count.
                ch_cnt_n[i] = '0;
            end else if (ch_cnt[i] == LAST) begin
                upd[i]      = 1'b1;
                ch_cnt_n[i] = '0;
            end else begin
                ch_cnt_n[i] = ch_cnt[i] + ONE;
            end
        end
    end

    // Next-state and output logic for the settle/run controller.
    always_comb begin
        state_n    = state;
        snap_n     = snap;
        init_cnt_n = init_cnt;
        dout_n     = dout;
        valid_n    = valid;
        step_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            S_INIT: begin
                if (sync2 != snap) begin
                    snap_n     = sync2;
                    init_cnt_n = '0;
                end else if (init_cnt == LAST) begin
                    dout_n  = snap;
                    valid_n = 1'b1;
                    state_n = S_RUN;
                end else begin
                    init_cnt_n = init_cnt + ONE;
                end
            end
            S_RUN: begin
                dout_n = dout ^ upd;
                step_n = upd[0] ^ upd[1];
                err_n  = upd[0] & upd[1];
            end
            default: state_n = S_INIT;
        endcase
        // A fresh error beats a coincident clear.
        sticky_n = err_n | (err_sticky & ~err_clr);
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_n;
    end

    // Datapath registers; step/err land with the new output values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap       <= 2'b00;
            init_cnt   <= '0;
            ch_cnt     <= '0;
            dout       <= 2'b00;
            valid      <= 1'b0;
            step       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            snap       <= snap_n;
            init_cnt   <= init_cnt_n;
            ch_cnt     <= ch_cnt_n;
            dout       <= dout_n;
            valid      <= valid_n;
            step       <= step_n;
            err        <= err_n;
            err_sticky <= sticky_n;
        end
    end

endmodule

// File: tb/tb_quadrature_debounce.sv
// Bench for quadrature_debounce: two instances (N=4 and N=1) share one
// stimulus stream and are compared every cycle against a history-based model.
module tb_quadrature_debounce;

    logic clk = 1'b0;
    logic rst, qa, qb, clr;
    logic a4, b4, v4, s4, e4, k4;
    logic a1, b1, v1, s1, e1, k1;
    logic [5:0] o4, o1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quadrature_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset(rst), .quadA_in(qa), .quadB_in(qb), .err_clr(clr),
        .quadA(a4), .quadB(b4), .valid(v4), .step(s4), .err(e4), .err_sticky(k4));

    quadrature_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(rst), .quadA_in(qa), .quadB_in(qb), .err_clr(clr),
        .quadA(a1), .quadB(b1), .valid(v1), .step(s1), .err(e1), .err_sticky(k1));

    assign o4 = {a4, b4, v4, s4, e4, k4};
    assign o1 = {a1, b1, v1, s1, e1, k1};

    // Model: the synchronised sample seen at edge e is the raw value driven
    // before edge e-2. Settle completes once the sample stream (with a
    // virtual 00 at index 0) has gone N edges since its last change. In RUN a
    // channel flips when its last N samples, all taken after RUN entry,
    // disagree with the current output.
    int         e;
    logic [1:0] raw_h  [0:2047];
    logic [1:0] s_hist [0:2047];
    int         nd     [2];
    bit         run    [2];
    int         ent    [2];
    logic [1:0] mo     [2];
    logic       mv [2], mstep [2], merr [2], mst [2];

    task automatic model_reset();
        e = 0;
        s_hist[0] = 2'b00;
        for (int d = 0; d < 2; d++) begin
            run[d] = 0; ent[d] = 0; mo[d] = 2'b00;
            mv[d] = 0; mstep[d] = 0; merr[d] = 0; mst[d] = 0;
        end
    endtask

    task automatic model_step();
        int c;
        logic [1:0] s, u;
        bit all;
        e++;
        raw_h[e] = {qb, qa};
        s = (e >= 3) ? raw_h[e-2] : 2'b00;
        s_hist[e] = s;
        c = 0;
        for (int j = 1; j <= e; j++) if (s_hist[j] != s_hist[j-1]) c = j;
        for (int d = 0; d < 2; d++) begin
            mstep[d] = 0; merr[d] = 0;
            if (!run[d]) begin
                if (e - c == nd[d]) begin
                    run[d] = 1; ent[d] = e; mo[d] = s; mv[d] = 1;
                end
            end else begin
                u = 2'b00;
                for (int ch = 0; ch < 2; ch++) begin
                    if (e - nd[d] + 1 > ent[d]) begin
                        all = 1;
                        for (int j = e - nd[d] + 1; j <= e; j++)
                            if (s_hist[j][ch] == mo[d][ch]) all = 0;
                        u[ch] = all;
                    end
                end
                mo[d]    = mo[d] ^ u;
                mstep[d] = (u == 2'b01) || (u == 2'b10);
                merr[d]  = (u == 2'b11);
            end
            mst[d] = merr[d] ? 1'b1 : (clr ? 1'b0 : mst[d]);
        end
    endtask

    function automatic logic [5:0] mvec(int d);
        return {mo[d][0], mo[d][1], mv[d], mstep[d], merr[d], mst[d]};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        model_step();
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Reset with inputs at 00 and run until both instances are in RUN.
    task automatic go00();
        qa = 0; qb = 0; clr = 0;
        hold_reset();
        repeat (6) tick();
    endtask

    task automatic test_reset();
        checks++; if (o4 !== 6'b0) begin errors++; $display("FAIL reset_state n4 got %b want 000000", o4); end
        checks++; if (o1 !== 6'b0) begin errors++; $display("FAIL reset_state n1 got %b want 000000", o1); end
        qa = 1; qb = 1; clr = 0;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL settle11 n4 e=%0d got %b want %b", e, o4, mvec(0)); end
            checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL settle11 n1 e=%0d got %b want %b", e, o1, mvec(1)); end
            if (e == 6) begin
                checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL settle11_early got valid=%b want 0", v4); end
            end
            if (e == 7) begin
                checks++; if ({a4, b4, v4, s4, e4} !== 5'b11100) begin errors++; $display("FAIL settle11_edge7 got %b want 11100", {a4, b4, v4, s4, e4}); end
            end
        end
    endtask

    task automatic test_single_step();
        int k, t, steps;
        go00();
        k = e + 1; qa = 1; t = -1; steps = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL single_step n4 e=%0d got %b want %b", e, o4, mvec(0)); end
            checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL single_step n1 e=%0d got %b want %b", e, o1, mvec(1)); end
            if (a4 && t < 0) t = e;
            if (s4) steps++;
            checks++; if (b4 !== 1'b0 || e4 !== 1'b0) begin errors++; $display("FAIL single_step_b got quadB=%b err=%b want 0 0", b4, e4); end
        end
        checks++; if (t != k + 5) begin errors++; $display("FAIL single_step_latency got edge %0d want %0d", t, k + 5); end
        checks++; if (steps != 1) begin errors++; $display("FAIL single_step_pulses got %0d want 1", steps); end
    endtask

    task automatic test_glitch();
        int steps, maxa;
        go00();
        for (int len = 3; len <= 5; len += 2) begin
            steps = 0; maxa = 0;
            for (int i = 0; i < len + 12; i++) begin
                qa = (i < len);
                tick();
                checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL glitch%0d n4 e=%0d got %b want %b", len, e, o4, mvec(0)); end
                checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL glitch%0d n1 e=%0d got %b want %b", len, e, o1, mvec(1)); end
                if (s4) steps++;
                if (a4) maxa = 1;
            end
            checks++; if (steps != ((len == 3) ? 0 : 2)) begin errors++; $display("FAIL glitch%0d_steps got %0d want %0d", len, steps, (len == 3) ? 0 : 2); end
            checks++; if (maxa != ((len == 3) ? 0 : 1)) begin errors++; $display("FAIL glitch%0d_quadA got %0d want %0d", len, maxa, (len == 3) ? 0 : 1); end
        end
    endtask

    task automatic test_both();
        int errs;
        go00();
        qa = 1; qb = 1; errs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL both_rise n4 e=%0d got %b want %b", e, o4, mvec(0)); end
            checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL both_rise n1 e=%0d got %b want %b", e, o1, mvec(1)); end
            if (e4) begin
                errs++;
                checks++; if ({a4, b4, s4, k4} !== 4'b1101) begin errors++; $display("FAIL both_rise_edge got %b want 1101", {a4, b4, s4, k4}); end
            end
        end
        checks++; if (errs != 1) begin errors++; $display("FAIL both_rise_err_pulses got %0d want 1", errs); end
        clr = 1; tick(); clr = 0;
        checks++; if (k4 !== 1'b0) begin errors++; $display("FAIL err_clr got sticky=%b want 0", k4); end
        checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL err_clr n1 got %b want %b", o1, mvec(1)); end
        // Clear held across the next double change: the set must win on its edge.
        qa = 0; qb = 0; clr = 1; errs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL both_fall n4 e=%0d got %b want %b", e, o4, mvec(0)); end
            checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL both_fall n1 e=%0d got %b want %b", e, o1, mvec(1)); end
            if (e4) begin
                errs++;
                checks++; if (k4 !== 1'b1) begin errors++; $display("FAIL set_beats_clr got sticky=%b want 1", k4); end
            end
        end
        clr = 0;
        checks++; if (errs != 1) begin errors++; $display("FAIL both_fall_err_pulses got %0d want 1", errs); end
    endtask

    task automatic test_reset_mid();
        go00();
        qb = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL mid_pre n4 e=%0d got %b want %b", e, o4, mvec(0)); end
        end
        rst = 1'b1; #1;
        checks++; if (o4 !== 6'b0) begin errors++; $display("FAIL mid_reset n4 got %b want 000000", o4); end
        checks++; if (o1 !== 6'b0) begin errors++; $display("FAIL mid_reset n1 got %b want 000000", o1); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL mid_resettle n4 e=%0d got %b want %b", e, o4, mvec(0)); end
            checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL mid_resettle n1 e=%0d got %b want %b", e, o1, mvec(1)); end
            if (e == 6) begin
                checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL mid_resettle_early got valid=%b want 0", v4); end
            end
            if (e == 7) begin
                checks++; if ({a4, b4, v4} !== 3'b011) begin errors++; $display("FAIL mid_resettle_edge7 got %b want 011", {a4, b4, v4}); end
            end
        end
        qb = 0;
    endtask

    task automatic test_n1();
        int k, t, highs;
        go00();
        k = e + 1; qa = 1; t = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL n1_step e=%0d got %b want %b", e, o1, mvec(1)); end
            if (a1 && t < 0) t = e;
        end
        checks++; if (t != k + 2) begin errors++; $display("FAIL n1_latency got edge %0d want %0d", t, k + 2); end
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            qb = (i == 0);
            tick();
            checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL n1_pulse e=%0d got %b want %b", e, o1, mvec(1)); end
            checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL n1_pulse n4 e=%0d got %b want %b", e, o4, mvec(0)); end
            if (b1) highs++;
        end
        checks++; if (highs != 1) begin errors++; $display("FAIL n1_pulse_width got %0d want 1", highs); end
    endtask

    task automatic test_random();
        int hold;
        logic [1:0] r;
        qa = 0; qb = 0; clr = 0;
        hold_reset();
        hold = 0;
        for (int i = 0; i < 500; i++) begin
            if (hold == 0) begin
                r = 2'($urandom_range(0, 3));
                qa = qa ^ r[0];
                qb = qb ^ r[1];
                hold = $urandom_range(1, 7);
            end
            hold--;
            clr = ($urandom_range(0, 7) == 0);
            tick();
            checks++; if (o4 !== mvec(0)) begin errors++; $display("FAIL random n4 e=%0d got %b want %b", e, o4, mvec(0)); end
            checks++; if (o1 !== mvec(1)) begin errors++; $display("FAIL random n1 e=%0d got %b want %b", e, o1, mvec(1)); end
        end
        clr = 0;
    endtask

    initial begin
        nd[0] = 4;
        nd[1] = 1;
        rst = 1'b1; qa = 0; qb = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_step();
        test_glitch();
        test_both();
        test_reset_mid();
        test_n1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
